// File: rtl/div_iter_param.sv
// Multicycle restoring divider: signed/unsigned quotient and remainder in WIDTH+1 cycles,
// with divide-by-zero / signed-overflow flags and abort-on-restart.
module div_iter_param #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             ctrl_DIV,
    input  logic             ctrl_SIGNED,
    input  logic [WIDTH-1:0] data_operandA,
    input  logic [WIDTH-1:0] data_operandB,
    output logic [WIDTH-1:0] data_result,
    output logic [WIDTH-1:0] data_remainder,
    output logic             data_exception,
    output logic             data_resultRDY,
    output logic             data_busy
);

    // Handshake: ctrl_DIV is a one-edge start strobe (no ready needed, it is always accepted,
    // aborting any op in flight); data_resultRDY is a one-cycle valid with no back-pressure.

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] part_rem;
    logic [WIDTH-1:0] quo_shift;
    logic [WIDTH-1:0] divisor;
    logic             sign_a, sign_b, div_zero, overflow;

    logic [WIDTH-1:0] mag_a, mag_b;
    logic [WIDTH:0]   shifted, trial;
    logic [WIDTH-1:0] quo_fixed, rem_fixed;
    logic [WIDTH-1:0] min_val;
    logic             last_step;

    assign min_val   = {1'b1, {(WIDTH-1){1'b0}}};
    assign mag_a     = (ctrl_SIGNED && data_operandA[WIDTH-1]) ? -data_operandA : data_operandA;
    assign mag_b     = (ctrl_SIGNED && data_operandB[WIDTH-1]) ? -data_operandB : data_operandB;
    // Restored remainder is always below the divisor, so WIDTH bits hold it between steps.
    assign shifted   = {part_rem, quo_shift[WIDTH-1]};
    assign trial     = shifted - {1'b0, divisor};
    assign quo_fixed = (sign_a ^ sign_b) ? -quo_shift : quo_shift;
    assign rem_fixed = sign_a ? -part_rem : part_rem;
    assign last_step = (count == CNT_W'(WIDTH - 1));

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (ctrl_DIV) state_next = RUN;
            RUN: begin
                if (ctrl_DIV) begin
                    state_next = RUN;
                end else if (last_step) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = ctrl_DIV ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count          <= '0;
            part_rem       <= '0;
            quo_shift      <= '0;
            divisor        <= '0;
            sign_a         <= 1'b0;
            sign_b         <= 1'b0;
            div_zero       <= 1'b0;
            overflow       <= 1'b0;
            data_result    <= '0;
            data_remainder <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
            data_busy      <= 1'b0;
        end else begin
            data_resultRDY <= 1'b0;
            if (state == FIX) begin
                data_resultRDY <= 1'b1;
                data_busy      <= 1'b0;
                if (div_zero) begin
                    data_result    <= '0;
                    data_remainder <= '0;
                    data_exception <= 1'b1;
                end else if (overflow) begin
                    data_result    <= min_val;
                    data_remainder <= '0;
                    data_exception <= 1'b1;
                end else begin
                    data_result    <= quo_fixed;
                    data_remainder <= rem_fixed;
                    data_exception <= 1'b0;
                end
            end
            // A start in FIX still lets the finishing result out above; elsewhere it aborts.
            if (ctrl_DIV) begin
                count     <= '0;
                part_rem  <= '0;
                quo_shift <= mag_a;
                divisor   <= mag_b;
                sign_a    <= ctrl_SIGNED & data_operandA[WIDTH-1];
                sign_b    <= ctrl_SIGNED & data_operandB[WIDTH-1];
                div_zero  <= (data_operandB == '0);
                overflow  <= ctrl_SIGNED && (data_operandA == min_val) && (data_operandB == '1);
                data_busy <= 1'b1;
            end else if (state == RUN) begin
                count     <= count + CNT_W'(1);
                quo_shift <= {quo_shift[WIDTH-2:0], ~trial[WIDTH]};
                part_rem  <= trial[WIDTH] ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
            end
        end
    end

endmodule
